// File: rtl/filter_serial_pkg.sv
// Shared constants, FSM state type and output scaling for the serial 3x3 filter core.
// Define FILTER_SERIAL_SAT_EN to saturate outputs instead of wrapping them.
package filter_serial_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ACC_W    = 20;
  localparam int unsigned IN_DIM   = 4;
  localparam int unsigned K_DIM    = 3;
  localparam int unsigned OUT_DIM  = 2;
  localparam int unsigned TAP_LAST = 8;

  typedef enum logic [1:0] {StLoad, StRun, StFinish, StDone} state_e;

  function automatic logic [DATA_W-1:0] scale_out(input logic [ACC_W-1:0] acc);
`ifdef FILTER_SERIAL_SAT_EN
    // Any bit above the output width means the value exceeds the output range.
    return (|acc[ACC_W-1:DATA_W]) ? '1 : acc[DATA_W-1:0];
`else
    return acc[DATA_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/filter_serial_mac.sv
// Unsigned 8x8 multiply-accumulate with synchronous clear (priority) and enable.
module filter_serial_mac
  import filter_serial_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    acc_d, acc_q;

  always_comb begin
    prod  = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/filter_serial_core.sv
// Serial 3x3 valid cross-correlation of a 4x4 tile: four MACs walk the nine taps, one per clock.
// Output scaling is selected by FILTER_SERIAL_SAT_EN (saturate) or its absence (wrap).
module filter_serial_core
  import filter_serial_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [0:DATA_W-1] a11, a12, a13, a14,
  input  logic [0:DATA_W-1] a21, a22, a23, a24,
  input  logic [0:DATA_W-1] a31, a32, a33, a34,
  input  logic [0:DATA_W-1] a41, a42, a43, a44,
  input  logic [0:DATA_W-1] b11, b12, b13,
  input  logic [0:DATA_W-1] b21, b22, b23,
  input  logic [0:DATA_W-1] b31, b32, b33,
  output logic [0:DATA_W-1] c11,
  output logic [0:DATA_W-1] c12,
  output logic [0:DATA_W-1] c21,
  output logic [0:DATA_W-1] c22,
  output logic              done
);

  logic [DATA_W-1:0] a_in [IN_DIM][IN_DIM];
  logic [DATA_W-1:0] b_in [K_DIM][K_DIM];
  logic [DATA_W-1:0] a_q  [IN_DIM][IN_DIM];
  logic [DATA_W-1:0] b_q  [K_DIM][K_DIM];
  logic [DATA_W-1:0] c_q  [OUT_DIM][OUT_DIM];
  logic [ACC_W-1:0]  acc  [OUT_DIM][OUT_DIM];

  state_e     state_q;
  logic [3:0] tap_q;
  logic [1:0] tap_r, tap_s;
  logic       done_q;
  logic       acc_clr, acc_en;

  always_comb begin
    a_in[0] = '{a11, a12, a13, a14};
    a_in[1] = '{a21, a22, a23, a24};
    a_in[2] = '{a31, a32, a33, a34};
    a_in[3] = '{a41, a42, a43, a44};
    b_in[0] = '{b11, b12, b13};
    b_in[1] = '{b21, b22, b23};
    b_in[2] = '{b31, b32, b33};
  end

  // Operands are captured once; ports are don't-care for the rest of the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '{default: '0};
      b_q <= '{default: '0};
    end else if (state_q == StLoad) begin
      a_q <= a_in;
      b_q <= b_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StLoad;
      tap_q   <= '0;
      c_q     <= '{default: '0};
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          tap_q   <= '0;
          state_q <= StRun;
        end
        StRun: begin
          if (tap_q == 4'(TAP_LAST)) begin
            state_q <= StFinish;
          end else begin
            tap_q <= tap_q + 4'd1;
          end
        end
        StFinish: begin
          for (int i = 0; i < OUT_DIM; i++) begin
            for (int j = 0; j < OUT_DIM; j++) begin
              c_q[i][j] <= scale_out(acc[i][j]);
            end
          end
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
        end
      endcase
    end
  end

  assign tap_r   = 2'(tap_q / 4'd3);
  assign tap_s   = 2'(tap_q % 4'd3);
  assign acc_clr = (state_q == StLoad);
  assign acc_en  = (state_q == StRun);

  for (genvar i = 0; i < OUT_DIM; i++) begin : g_row
    for (genvar j = 0; j < OUT_DIM; j++) begin : g_col
      logic [1:0] a_row, a_col;
      assign a_row = 2'(i) + tap_r;
      assign a_col = 2'(j) + tap_s;

      filter_serial_mac u_mac (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (acc_clr),
        .en_i   (acc_en),
        .a_i    (a_q[a_row][a_col]),
        .b_i    (b_q[tap_r][tap_s]),
        .acc_o  (acc[i][j])
      );
    end
  end

  assign c11  = c_q[0][0];
  assign c12  = c_q[0][1];
  assign c21  = c_q[1][0];
  assign c22  = c_q[1][1];
  assign done = done_q;

endmodule

// File: tb/tb_filter_serial_core.sv
// Directed bench for filter_serial_core: latency, results, sticky done, reset and input isolation.
module tb_filter_serial_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:7] a11, a12, a13, a14, a21, a22, a23, a24;
  logic [0:7] a31, a32, a33, a34, a41, a42, a43, a44;
  logic [0:7] b11, b12, b13, b21, b22, b23, b31, b32, b33;
  logic [0:7] c11, c12, c21, c22;
  logic       done;

  logic [7:0] a_v [4][4];
  logic [7:0] b_v [3][3];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign a11 = a_v[0][0]; assign a12 = a_v[0][1]; assign a13 = a_v[0][2]; assign a14 = a_v[0][3];
  assign a21 = a_v[1][0]; assign a22 = a_v[1][1]; assign a23 = a_v[1][2]; assign a24 = a_v[1][3];
  assign a31 = a_v[2][0]; assign a32 = a_v[2][1]; assign a33 = a_v[2][2]; assign a34 = a_v[2][3];
  assign a41 = a_v[3][0]; assign a42 = a_v[3][1]; assign a43 = a_v[3][2]; assign a44 = a_v[3][3];
  assign b11 = b_v[0][0]; assign b12 = b_v[0][1]; assign b13 = b_v[0][2];
  assign b21 = b_v[1][0]; assign b22 = b_v[1][1]; assign b23 = b_v[1][2];
  assign b31 = b_v[2][0]; assign b32 = b_v[2][1]; assign b33 = b_v[2][2];

  filter_serial_core dut (
    .clk (clk), .rst (rst),
    .a11 (a11), .a12 (a12), .a13 (a13), .a14 (a14),
    .a21 (a21), .a22 (a22), .a23 (a23), .a24 (a24),
    .a31 (a31), .a32 (a32), .a33 (a33), .a34 (a34),
    .a41 (a41), .a42 (a42), .a43 (a43), .a44 (a44),
    .b11 (b11), .b12 (b12), .b13 (b13),
    .b21 (b21), .b22 (b22), .b23 (b23),
    .b31 (b31), .b32 (b32), .b33 (b33),
    .c11 (c11), .c12 (c12), .c21 (c21), .c22 (c22),
    .done (done)
  );

  task automatic set_a_nominal();
    a_v[0] = '{8'd3, 8'd1, 8'd2, 8'd0};
    a_v[1] = '{8'd3, 8'd1, 8'd2, 8'd2};
    a_v[2] = '{8'd0, 8'd2, 8'd3, 8'd1};
    a_v[3] = '{8'd1, 8'd3, 8'd3, 8'd2};
  endtask

  task automatic set_b_nominal();
    b_v[0] = '{8'd3, 8'd0, 8'd3};
    b_v[1] = '{8'd3, 8'd1, 8'd2};
    b_v[2] = '{8'd1, 8'd1, 8'd1};
  endtask

  task automatic fill_a(input logic [7:0] v);
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) a_v[i][j] = v;
  endtask

  task automatic fill_b(input logic [7:0] v);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) b_v[i][j] = v;
  endtask

  // Hold reset for two cycles and release on a falling edge; the next rising edge is edge 1.
  task automatic pulse_reset();
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set_a_nominal();
    set_b_nominal();
    rst = 1'b0;
    #12;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL reset_done: got %b want 0", done);
    end
    n_cmp++;
    if ({c11, c12, c21, c22} !== 32'h0) begin
      n_bad++; $display("FAIL reset_outputs: got %0d %0d %0d %0d want 0 0 0 0", c11, c12, c21, c22);
    end
  endtask

  task automatic test_nominal();
    set_a_nominal();
    set_b_nominal();
    pulse_reset();
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, c11, c12, c21, c22} !== 33'h0) begin
      n_bad++;
      $display("FAIL nominal_edge10: got done=%b c=%0d %0d %0d %0d want all 0",
               done, c11, c12, c21, c22);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL nominal_done_edge11: got %b want 1", done);
    end
    n_cmp++;
    if ({c11, c12, c21, c22} !== {8'd34, 8'd18, 8'd30, 8'd28}) begin
      n_bad++; $display("FAIL nominal_values: got %0d %0d %0d %0d want 34 18 30 28", c11, c12, c21, c22);
    end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, c11, c12, c21, c22} !== {1'b1, 8'd34, 8'd18, 8'd30, 8'd28}) begin
      n_bad++;
      $display("FAIL nominal_sticky: got done=%b c=%0d %0d %0d %0d want 1 34 18 30 28",
               done, c11, c12, c21, c22);
    end
  endtask

  task automatic test_zero();
    fill_a(8'd0);
    fill_b(8'd0);
    pulse_reset();
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL zero_done_edge10: got %b want 0", done);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL zero_done_edge11: got %b want 1", done);
    end
    n_cmp++;
    if ({c11, c12, c21, c22} !== 32'h0) begin
      n_bad++; $display("FAIL zero_values: got %0d %0d %0d %0d want 0 0 0 0", c11, c12, c21, c22);
    end
  endtask

  task automatic test_full_scale();
    logic [7:0] want;
`ifdef FILTER_SERIAL_SAT_EN
    want = 8'd255;
`else
    want = 8'd9;
`endif
    fill_a(8'd255);
    fill_b(8'd255);
    pulse_reset();
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if ({done, c11, c12, c21, c22} !== 33'h0) begin
      n_bad++;
      $display("FAIL full_edge10: got done=%b c=%0d %0d %0d %0d want all 0", done, c11, c12, c21, c22);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL full_done_edge11: got %b want 1", done);
    end
    n_cmp++;
    if ({c11, c12, c21, c22} !== {want, want, want, want}) begin
      n_bad++;
      $display("FAIL full_values: got %0d %0d %0d %0d want %0d each", c11, c12, c21, c22, want);
    end
  endtask

  task automatic test_identity();
    set_a_nominal();
    fill_b(8'd0);
    b_v[1][1] = 8'd1;
    pulse_reset();
    repeat (11) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++; $display("FAIL identity_done: got %b want 1", done);
    end
    n_cmp++;
    if ({c11, c12, c21, c22} !== {8'd1, 8'd2, 8'd2, 8'd3}) begin
      n_bad++; $display("FAIL identity_values: got %0d %0d %0d %0d want 1 2 2 3", c11, c12, c21, c22);
    end
  endtask

  task automatic test_mid_reset();
    set_a_nominal();
    set_b_nominal();
    pulse_reset();
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({done, c11, c12, c21, c22} !== 33'h0) begin
      n_bad++;
      $display("FAIL async_clear: got done=%b c=%0d %0d %0d %0d want all 0", done, c11, c12, c21, c22);
    end
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({done, c11, c12, c21, c22} !== 33'h0) begin
      n_bad++;
      $display("FAIL midrun_clear: got done=%b c=%0d %0d %0d %0d want all 0", done, c11, c12, c21, c22);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL restart_done_edge10: got %b want 0", done);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, c11, c12, c21, c22} !== {1'b1, 8'd34, 8'd18, 8'd30, 8'd28}) begin
      n_bad++;
      $display("FAIL restart_values: got done=%b c=%0d %0d %0d %0d want 1 34 18 30 28",
               done, c11, c12, c21, c22);
    end
  endtask

  task automatic test_input_change();
    set_a_nominal();
    set_b_nominal();
    pulse_reset();
    @(posedge clk);
    #1;
    fill_a(8'd0);
    repeat (9) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL isolate_done_edge10: got %b want 0", done);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, c11, c12, c21, c22} !== {1'b1, 8'd34, 8'd18, 8'd30, 8'd28}) begin
      n_bad++;
      $display("FAIL isolate_values: got done=%b c=%0d %0d %0d %0d want 1 34 18 30 28",
               done, c11, c12, c21, c22);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero();
    test_full_scale();
    test_identity();
    test_mid_reset();
    test_input_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
